// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller for a word-wide data memory with no byte strobes; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning them.
module lsu_dmem_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int DMEM_SZ_IN_KB = 1,
    localparam int ADDR_WIDTH   = $clog2(DMEM_SZ_IN_KB * 1024 * 8)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic                  req_err;
    logic [ADDR_WIDTH-1:0] addr_aligned;

    assign req_ready = (state == S_IDLE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        addr_aligned = req_addr;
        if (req_size == SZ_HALF)
            addr_aligned[0] = 1'b0;
        else if (req_size == SZ_WORD)
            addr_aligned[1:0] = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = (req_size == SZ_BAD)
               || ((req_size == SZ_HALF) && req_addr[0])
               || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        req_err = (req_size == SZ_BAD);
`endif
    end

    // Pick the addressed lane out of the returned word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: extract = {{24{b[7] & ~uns}}, b};
            SZ_HALF: extract = {{16{h[15] & ~uns}}, h};
            default: extract = word;
        endcase
    endfunction

    // Replace only the addressed lane of the base word; other bytes are preserved.
    function automatic logic [31:0] merge(input logic [31:0] base, input logic [15:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
        merge = base;
        if (size == SZ_BYTE)
            merge[{lane, 3'b000} +: 8] = wd[7:0];
        else
            merge[{lane[1], 4'b0000} +: 16] = wd;
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state        <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid    <= 1'b0;
                    rsp_rdata    <= '0;
                    rsp_err      <= 1'b0;
                    mem_write_en <= 1'b0;
                    mem_addr     <= '0;
                    mem_wdata    <= '0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        lane_q  <= addr_aligned[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            state        <= S_WR;
                            mem_write_en <= 1'b1;
                            mem_addr     <= addr_aligned;
                            mem_wdata    <= req_wdata;
                        end else begin
                            state    <= S_RD;
                            mem_addr <= addr_aligned;
                        end
                    end
                end
                S_RD: begin
                    if (we_q) begin
                        state        <= S_WR;
                        mem_write_en <= 1'b1;
                        mem_wdata    <= merge(mem_rdata, wdata_q, size_q, lane_q);
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= extract(mem_rdata, size_q, uns_q, lane_q);
                        mem_addr  <= '0;
                    end
                end
                S_WR: begin
                    state        <= S_RESP;
                    rsp_valid    <= 1'b1;
                    mem_write_en <= 1'b0;
                    mem_addr     <= '0;
                    mem_wdata    <= '0;
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed self-checking bench for lsu_dmem_ctrl with a combinational-read word memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
module tb_lsu_dmem_ctrl;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_write_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0] mem_model [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_dmem_ctrl dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_model[mem_addr[9:2]];
    always @(posedge clk) if (mem_write_en) mem_model[mem_addr[9:2]] <= mem_wdata;

    // Issue one request and watch up to 8 cycles after the accept edge; cycle k is sampled at the k-th negedge.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [AW-1:0] addr, input logic [31:0] wdata,
                           output logic acc_ok, output int lat, output int wr_cnt, output int wr_at,
                           output logic [AW-1:0] c1_addr, output logic [31:0] rdata,
                           output logic err, output logic tail_valid);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        acc_ok = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; wr_cnt = 0; wr_at = -1; rdata = 32'hx; err = 1'bx; c1_addr = 'x;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) c1_addr = mem_addr;
            if (mem_write_en) begin wr_cnt++; wr_at = k; end
            if (rsp_valid) begin lat = k; rdata = rsp_rdata; err = rsp_err; end
        end
        @(negedge clk);
        tail_valid = rsp_valid;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_rsp: got v=%b e=%b d=%h expected 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (mem_write_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_mem: got we=%b a=%h d=%h expected 0/0/0", mem_write_en, mem_addr, mem_wdata); end
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        logic acc, err, tail; int lat, wc, wa; logic [AW-1:0] a1; logic [31:0] rd;
        run_req(1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL sw_accept: got %b expected 1", acc); end
        checks++; if (wc != 1 || wa != 1) begin failures++; $display("FAIL sw_write_cycle: got cnt=%0d at=%0d expected 1 at 1", wc, wa); end
        checks++; if (lat != 2 || err !== 1'b0 || rd !== 32'h0) begin
            failures++; $display("FAIL sw_rsp: got lat=%0d err=%b d=%h expected 2/0/0", lat, err, rd); end
        checks++; if (tail !== 1'b0) begin failures++; $display("FAIL sw_pulse_width: got rsp_valid=%b after RESP expected 0", tail); end
        checks++; if (mem_model[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem: got %h expected deadbeef", mem_model[4]); end
        run_req(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (lat != 2 || err !== 1'b0 || rd !== 32'hDEADBEEF || wc != 0) begin
            failures++; $display("FAIL lw_rsp: got lat=%0d err=%b d=%h wr=%0d expected 2/0/deadbeef/0", lat, err, rd, wc); end
    endtask

    task automatic test_subword_store();
        logic acc, err, tail; int lat, wc, wa; logic [AW-1:0] a1; logic [31:0] rd;
        run_req(1'b1, 2'b10, 1'b0, 13'h010, 32'h11223344, acc, lat, wc, wa, a1, rd, err, tail);
        run_req(1'b1, 2'b00, 1'b0, 13'h013, 32'h000000A5, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (a1 !== 13'h013) begin failures++; $display("FAIL sb_rd_addr: got %h expected 013", a1); end
        checks++; if (wc != 1 || wa != 2) begin failures++; $display("FAIL sb_write_cycle: got cnt=%0d at=%0d expected 1 at 2", wc, wa); end
        checks++; if (lat != 3 || err !== 1'b0) begin failures++; $display("FAIL sb_latency: got lat=%0d err=%b expected 3/0", lat, err); end
        checks++; if (mem_model[4] !== 32'hA5223344) begin failures++; $display("FAIL sb_merge: got %h expected a5223344", mem_model[4]); end
        run_req(1'b1, 2'b01, 1'b0, 13'h012, 32'h1234BEEF, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (mem_model[4] !== 32'hBEEF3344 || lat != 3) begin
            failures++; $display("FAIL sh_merge: got %h lat=%0d expected beef3344 lat=3", mem_model[4], lat); end
    endtask

    task automatic test_subword_loads();
        logic acc, err, tail; int lat, wc, wa; logic [AW-1:0] a1; logic [31:0] rd;
        logic [AW-1:0] addrs [6] = '{13'h020, 13'h021, 13'h021, 13'h022, 13'h022, 13'h023};
        logic [1:0]    sizes [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic          unss  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0]   exps  [6] = '{32'h0000007F, 32'hFFFFFFF0, 32'h000000F0,
                                     32'hFFFF8001, 32'h00008001, 32'hFFFFFF80};
        run_req(1'b1, 2'b10, 1'b0, 13'h020, 32'h8001F07F, acc, lat, wc, wa, a1, rd, err, tail);
        for (int i = 0; i < 6; i++) begin
            run_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, acc, lat, wc, wa, a1, rd, err, tail);
            checks++; if (rd !== exps[i] || lat != 2 || err !== 1'b0) begin
                failures++; $display("FAIL subload_%0d: got d=%h lat=%0d err=%b expected %h/2/0", i, rd, lat, err, exps[i]); end
        end
    endtask

    task automatic test_errors();
        logic acc, err, tail; int lat, wc, wa; logic [AW-1:0] a1; logic [31:0] rd;
        run_req(1'b1, 2'b10, 1'b0, 13'h030, 32'hCAFEF00D, acc, lat, wc, wa, a1, rd, err, tail);
        run_req(1'b0, 2'b11, 1'b0, 13'h030, 32'h0, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (lat != 1 || err !== 1'b1 || rd !== 32'h0 || wc != 0) begin
            failures++; $display("FAIL bad_size_load: got lat=%0d err=%b d=%h wr=%0d expected 1/1/0/0", lat, err, rd, wc); end
        run_req(1'b1, 2'b11, 1'b0, 13'h030, 32'hFFFFFFFF, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (lat != 1 || err !== 1'b1 || wc != 0 || mem_model[12] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL bad_size_store: got lat=%0d err=%b wr=%0d mem=%h expected 1/1/0/cafef00d", lat, err, wc, mem_model[12]); end
        run_req(1'b0, 2'b10, 1'b0, 13'h031, 32'h0, acc, lat, wc, wa, a1, rd, err, tail);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL misaligned_lw: got lat=%0d err=%b d=%h expected 1/1/0", lat, err, rd); end
        run_req(1'b0, 2'b01, 1'b0, 13'h023, 32'h0, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL misaligned_lh: got lat=%0d err=%b d=%h expected 1/1/0", lat, err, rd); end
`else
        checks++; if (lat != 2 || err !== 1'b0 || rd !== 32'hCAFEF00D) begin
            failures++; $display("FAIL misaligned_lw: got lat=%0d err=%b d=%h expected 2/0/cafef00d", lat, err, rd); end
        run_req(1'b0, 2'b01, 1'b0, 13'h023, 32'h0, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (lat != 2 || err !== 1'b0 || rd !== 32'hFFFF8001) begin
            failures++; $display("FAIL misaligned_lh: got lat=%0d err=%b d=%h expected 2/0/ffff8001", lat, err, rd); end
`endif
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 13'h010; req_wdata = 32'h0;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_ready: got %b expected 1", req_ready); end
        @(posedge clk);
        #1 req_addr = 13'h020;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
            if (k == 1 || k == 2 || k == 4) begin
                checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_c%0d: got %b expected 0", k, req_ready); end
            end
            if (k == 2) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEF3344) begin
                    failures++; $display("FAIL b2b_rsp1: got v=%b d=%h expected 1/beef3344", rsp_valid, rsp_rdata); end
            end
            if (k == 3) begin
                checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_second_ready: got %b expected 1", req_ready); end
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
            if (k == 5) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h8001F07F) begin
                    failures++; $display("FAIL b2b_rsp2: got v=%b d=%h expected 1/8001f07f", rsp_valid, rsp_rdata); end
            end
        end
        checks++; if (pulses != 2) begin failures++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        logic acc, err, tail; int lat, wc, wa; logic [AW-1:0] a1; logic [31:0] rd;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 13'h021; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_write_en !== 1'b1) begin failures++; $display("FAIL rst_mid_in_wr: got we=%b expected 1", mem_write_en); end
        #1 arst_n = 1'b0;
        #1;
        checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL rst_mid_we_async: got we=%b expected 0", mem_write_en); end
        repeat (3) begin @(negedge clk); if (rsp_valid) pulses++; end
        checks++; if (pulses != 0 || mem_model[8] !== 32'h8001F07F) begin
            failures++; $display("FAIL rst_mid_abort: got pulses=%0d mem=%h expected 0/8001f07f", pulses, mem_model[8]); end
        arst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0
                      || mem_write_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
            failures++; $display("FAIL rst_mid_after: got rdy=%b v=%b e=%b d=%h we=%b a=%h wd=%h expected 1/0/0/0/0/0/0",
                                 req_ready, rsp_valid, rsp_err, rsp_rdata, mem_write_en, mem_addr, mem_wdata); end
        run_req(1'b0, 2'b10, 1'b0, 13'h020, 32'h0, acc, lat, wc, wa, a1, rd, err, tail);
        checks++; if (acc !== 1'b1 || lat != 2 || rd !== 32'h8001F07F) begin
            failures++; $display("FAIL rst_mid_recover: got acc=%b lat=%0d d=%h expected 1/2/8001f07f", acc, lat, rd); end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_subword_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
